// File: rtl/periph_demux_pkg.sv
// Shared constants and helpers for the peripheral demultiplexer.
// Destination encoding reserves value NB_TARGETS for unmapped accesses.
package periph_demux_pkg;

  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

  function automatic int dest_width(input int nb_targets);
    return $clog2(nb_targets + 1);
  endfunction

endpackage

// File: rtl/periph_demux_tracker.sv
// Outstanding-transaction tracker: count, destination, unmapped pending.
// Produces admission and unexpected-response detection.
module periph_demux_tracker
  import periph_demux_pkg::*;
#(
  parameter int NB_TARGETS      = 2,
  parameter int MAX_OUTSTANDING = 4,
  localparam int DW             = dest_width(NB_TARGETS)
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic [DW-1:0]         sel,
  input  logic                  gnt,
  input  logic                  retire,
  input  logic [NB_TARGETS-1:0] rsp_valid,
  output logic                  allow,
  output logic [DW-1:0]         dest,
  output logic                  busy,
  output logic                  unm_pend,
  output logic                  proto_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [DW-1:0] UNM = DW'(NB_TARGETS);
  localparam logic [CW-1:0] MAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dest_q;
  logic          unm_q;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      dest_q <= '0;
      unm_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CW'(gnt) - CW'(retire);
      if (gnt) dest_q <= sel;
      unm_q <= gnt && (sel == UNM);
    end
  end

  // Registered state only: a target switch waits for a full drain.
  assign allow = (cnt_q == '0) ||
                 ((dest_q == sel) && (cnt_q < MAX));

  assign dest     = dest_q;
  assign busy     = (cnt_q != '0);
  assign unm_pend = unm_q;

  always_comb begin
    proto_err = 1'b0;
    for (int j = 0; j < NB_TARGETS; j++) begin
      if (rsp_valid[j] && (!busy || dest_q != DW'(j)))
        proto_err = 1'b1;
    end
    if (!rst_ni) proto_err = 1'b0;
  end

endmodule

// File: rtl/periph_demux_n.sv
// N-target peripheral demultiplexer with in-order response tracking
// and internal error completion for unmapped addresses.
module periph_demux_n
  import periph_demux_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int NB_TARGETS      = 2,
  parameter int REGION_LSB      = 14,
  parameter int REGION_MSB      = 19,
  parameter logic [REGION_MSB-REGION_LSB:0] REGION_ID = 6'b000001,
  parameter int TGT_LSB         = 10,
  parameter int TGT_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rst_ni,
  input  logic                           data_req_i,
  input  logic [ADDR_WIDTH-1:0]          data_add_i,
  input  logic                           data_we_n_i,
  input  logic [DATA_WIDTH-1:0]          data_wdata_i,
  input  logic [BE_WIDTH-1:0]            data_be_i,
  output logic                           data_gnt_o,
  output logic                           data_r_valid_o,
  output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
  output logic                           data_r_opc_o,
  output logic [NB_TARGETS-1:0]          tgt_req_o,
  output logic [ADDR_WIDTH-1:0]          tgt_add_o,
  output logic                           tgt_we_n_o,
  output logic [DATA_WIDTH-1:0]          tgt_wdata_o,
  output logic [BE_WIDTH-1:0]            tgt_be_o,
  input  logic [NB_TARGETS-1:0]          tgt_gnt_i,
  input  logic [NB_TARGETS-1:0]          tgt_r_valid_i,
  input  logic [NB_TARGETS*DATA_WIDTH-1:0] tgt_r_rdata_i,
  input  logic [NB_TARGETS-1:0]          tgt_r_opc_i,
  output logic                           proto_err_o
);

  localparam int DW = dest_width(NB_TARGETS);
  localparam logic [DW-1:0] UNM = DW'(NB_TARGETS);
  localparam int XW = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
  localparam logic [XW-1:0] UNM_EXT = XW'(UNMAPPED_RDATA);

  logic [TGT_WIDTH-1:0] tidx;
  logic                 mapped;
  logic [DW-1:0]        sel;
  logic [DW-1:0]        dest;
  logic                 allow;
  logic                 busy;
  logic                 unm_pend;
  logic                 gnt_sel;

  assign tidx   = data_add_i[TGT_LSB +: TGT_WIDTH];
  assign mapped = (data_add_i[REGION_MSB:REGION_LSB] == REGION_ID) &&
                  (32'(tidx) < NB_TARGETS);
  assign sel    = mapped ? DW'(tidx) : UNM;

  assign tgt_add_o   = data_add_i;
  assign tgt_we_n_o  = data_we_n_i;
  assign tgt_wdata_o = data_wdata_i;
  assign tgt_be_o    = data_be_i;

  always_comb begin
    tgt_req_o = '0;
    gnt_sel   = 1'b0;
    for (int k = 0; k < NB_TARGETS; k++) begin
      if (mapped && sel == DW'(k)) begin
        tgt_req_o[k] = data_req_i & allow & rst_ni;
        gnt_sel      = tgt_gnt_i[k];
      end
    end
  end

  // Unmapped accesses are accepted internally without a target grant.
  assign data_gnt_o = rst_ni & allow & data_req_i &
                      (mapped ? gnt_sel : 1'b1);

  always_comb begin
    data_r_valid_o = 1'b0;
    data_r_rdata_o = '0;
    data_r_opc_o   = 1'b0;
    if (dest == UNM) begin
      data_r_valid_o = unm_pend;
      data_r_rdata_o = UNM_EXT[DATA_WIDTH-1:0];
      data_r_opc_o   = 1'b1;
    end else if (busy) begin
      for (int k = 0; k < NB_TARGETS; k++) begin
        if (dest == DW'(k)) begin
          data_r_valid_o = tgt_r_valid_i[k];
          data_r_rdata_o = tgt_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
          data_r_opc_o   = tgt_r_opc_i[k];
        end
      end
    end
    if (!rst_ni) data_r_valid_o = 1'b0;
  end

  periph_demux_tracker #(
    .NB_TARGETS      (NB_TARGETS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_tracker (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .sel       (sel),
    .gnt       (data_gnt_o),
    .retire    (data_r_valid_o),
    .rsp_valid (tgt_r_valid_i),
    .allow     (allow),
    .dest      (dest),
    .busy      (busy),
    .unm_pend  (unm_pend),
    .proto_err (proto_err_o)
  );

endmodule

// File: tb/tb_periph_demux_n.sv
// Self-checking bench for periph_demux_n: directed cases plus random
// traffic against a queue-based reference of outstanding transactions.
module tb_periph_demux_n;

  localparam int NT   = 2;
  localparam int MAXO = 4;
  localparam int UNM  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] add;
  logic        we_n;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_opc;
  logic [1:0]  t_req;
  logic [31:0] t_add;
  logic        t_we_n;
  logic [31:0] t_wdata;
  logic [3:0]  t_be;
  logic [1:0]  t_gnt;
  logic [1:0]  t_rvalid;
  logic [63:0] t_rdata;
  logic [1:0]  t_ropc;
  logic        perr;

  int n_pass  = 0;
  int n_total = 0;
  int q[$];
  bit m_gnt;
  logic       o_gnt, o_val, o_opc, o_perr;
  logic [1:0] o_req;
  logic [31:0] o_rd;

  always #5 clk = ~clk;

  periph_demux_n dut (
    .clk            (clk),
    .rst_ni         (rst_n),
    .data_req_i     (req),
    .data_add_i     (add),
    .data_we_n_i    (we_n),
    .data_wdata_i   (wdata),
    .data_be_i      (be),
    .data_gnt_o     (gnt),
    .data_r_valid_o (r_valid),
    .data_r_rdata_o (r_rdata),
    .data_r_opc_o   (r_opc),
    .tgt_req_o      (t_req),
    .tgt_add_o      (t_add),
    .tgt_we_n_o     (t_we_n),
    .tgt_wdata_o    (t_wdata),
    .tgt_be_o       (t_be),
    .tgt_gnt_i      (t_gnt),
    .tgt_r_valid_i  (t_rvalid),
    .tgt_r_rdata_i  (t_rdata),
    .tgt_r_opc_i    (t_ropc),
    .proto_err_o    (perr)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int decode(input logic [31:0] a);
    int region;
    int idx;
    region = int'((a >> 14) & 32'h3F);
    idx    = int'((a >> 10) & 32'hF);
    if (region == 1 && idx < NT) return idx;
    return UNM;
  endfunction

  task automatic step(input string tag);
    int sel;
    bit allow, e_gnt, e_val, e_perr, e_opc;
    logic [1:0]  e_req;
    logic [31:0] e_rd;
    @(negedge clk);
    #1;
    sel   = decode(add);
    allow = (q.size() == 0) || (q[$] == sel && q.size() < MAXO);
    e_gnt = rst_n && req && allow && (sel == UNM || t_gnt[sel]);
    e_req = (rst_n && req && allow && sel != UNM) ? 2'(1 << sel) : 2'b00;
    e_val = 0; e_rd = '0; e_opc = 0; e_perr = 0;
    if (q.size() > 0) begin
      if (q[0] == UNM) begin
        e_val = 1; e_rd = 32'hDEAD_BEEF; e_opc = 1;
      end else begin
        e_val = t_rvalid[q[0]];
        e_rd  = t_rdata[q[0]*32 +: 32];
        e_opc = t_ropc[q[0]];
      end
    end
    for (int j = 0; j < NT; j++)
      if (t_rvalid[j] && (q.size() == 0 || q[0] != j)) e_perr = 1;
    if (!rst_n) begin e_val = 0; e_perr = 0; end
    o_gnt = gnt; o_req = t_req; o_val = r_valid;
    o_rd = r_rdata; o_opc = r_opc; o_perr = perr;
    check({tag, ".gnt"}, 64'(gnt), 64'(e_gnt));
    check({tag, ".tgt_req"}, 64'(t_req), 64'(e_req));
    check({tag, ".r_valid"}, 64'(r_valid), 64'(e_val));
    check({tag, ".proto_err"}, 64'(perr), 64'(e_perr));
    check({tag, ".bcast"}, {23'd0, t_we_n, t_be, t_wdata, t_add},
          {23'd0, we_n, be, wdata, add});
    if (e_val) begin
      check({tag, ".rdata"}, 64'(r_rdata), 64'(e_rd));
      check({tag, ".opc"}, 64'(r_opc), 64'(e_opc));
    end
    m_gnt = e_gnt;
    @(posedge clk);
    if (!rst_n) q.delete();
    else begin
      if (e_val) void'(q.pop_front());
      if (e_gnt) q.push_back(sel);
    end
    #1;
  endtask

  initial begin
    rst_n = 0; req = 1; add = 32'h1020_4000; we_n = 1;
    wdata = 32'hCAFE_0001; be = 4'hF; t_gnt = 2'b11;
    t_rvalid = 2'b00; t_rdata = '0; t_ropc = 2'b00;

    // reset holds everything quiet even with a request pending
    repeat (3) begin
      step("reset");
      check("reset.gnt_lit", 64'(o_gnt), 64'd0);
    end
    rst_n = 1;

    // mapped read to target 1
    add = 32'h1020_4400; t_gnt = 2'b10;
    step("map_req");
    check("map.req_lit", 64'(o_req), 64'h2);
    check("map.gnt_lit", 64'(o_gnt), 64'h1);
    req = 0; t_gnt = 2'b00;
    step("map_wait");
    t_rvalid = 2'b10; t_rdata = {32'h1234_5678, 32'h0};
    step("map_rsp");
    check("map.rdata_lit", 64'(o_rd), 64'h1234_5678);
    check("map.opc_lit", 64'(o_opc), 64'h0);
    t_rvalid = 2'b00;

    // two unmapped accesses back to back
    req = 1; add = 32'h1000_0000;
    step("unm1");
    check("unm1.gnt_lit", 64'(o_gnt), 64'h1);
    add = 32'h1020_7C00;
    step("unm2");
    check("unm2.gnt_lit", 64'(o_gnt), 64'h1);
    check("unm1.rd_lit", 64'(o_rd), 64'hDEAD_BEEF);
    req = 0;
    step("unm_drain");
    check("unm2.val_lit", 64'(o_val), 64'h1);
    check("unm2.opc_lit", 64'(o_opc), 64'h1);

    // outstanding limit on target 0
    req = 1; add = 32'h1020_4000; t_gnt = 2'b01;
    for (int i = 0; i < 5; i++) step("limit");
    check("limit.5th_held", 64'(o_gnt), 64'h0);
    t_rvalid = 2'b01; t_rdata = {32'h0, 32'hA5A5_0000};
    step("limit_retire");
    check("limit.full_nogrant", 64'(o_gnt), 64'h0);
    t_rvalid = 2'b00;
    step("limit_resume");
    check("limit.resume", 64'(o_gnt), 64'h1);
    req = 0; t_rvalid = 2'b01;
    for (int i = 0; i < 4; i++) step("limit_drain");
    t_rvalid = 2'b00;

    // target switch waits for a complete drain
    req = 1; add = 32'h1020_4000; t_gnt = 2'b11;
    step("sw_a"); step("sw_b");
    add = 32'h1020_4400;
    step("sw_held");
    t_rvalid = 2'b01;
    step("sw_drain1"); step("sw_drain2");
    check("sw.held_at_drain", 64'(o_gnt), 64'h0);
    t_rvalid = 2'b00;
    step("sw_grant");
    check("sw.grant", 64'(o_req), 64'h2);
    req = 0; t_rvalid = 2'b10; t_ropc = 2'b10;
    step("sw_rsp");
    t_rvalid = 2'b00; t_ropc = 2'b00;

    // spurious responses: wrong target, then nothing outstanding
    req = 1; add = 32'h1020_4000;
    step("sp_req");
    req = 0; t_rvalid = 2'b10;
    step("sp_wrong");
    check("sp.wrong_perr", 64'(o_perr), 64'h1);
    check("sp.wrong_noval", 64'(o_val), 64'h0);
    t_rvalid = 2'b01;
    step("sp_ok");
    t_rvalid = 2'b10;
    step("sp_idle");
    check("sp.idle_perr", 64'(o_perr), 64'h1);
    t_rvalid = 2'b00;

    // reset abandons in-flight transactions
    req = 1; add = 32'h1020_4000;
    step("rf_a"); step("rf_b");
    req = 0; rst_n = 0;
    step("rf_rst");
    rst_n = 1; t_rvalid = 2'b01;
    step("rf_late");
    check("rf.late_perr", 64'(o_perr), 64'h1);
    t_rvalid = 2'b00;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bit hold;
      hold  = req && !m_gnt && rst_n;
      rst_n = ($urandom_range(0, 199) != 0);
      if (!hold) begin
        int k;
        req = ($urandom_range(0, 3) != 0);
        k   = $urandom_range(0, 3);
        add = $urandom;
        if (k < 2) begin
          add[19:14] = 6'd1; add[13:10] = 4'(k);
        end else if (k == 2) begin
          add[19:14] = 6'd1; add[13:10] = 4'($urandom_range(2, 15));
        end else begin
          add[19:14] = 6'($urandom_range(2, 63));
        end
        we_n = 1'($urandom); wdata = $urandom; be = 4'($urandom);
      end
      for (int j = 0; j < NT; j++) begin
        t_gnt[j] = ($urandom_range(0, 3) != 0);
        if (q.size() > 0 && q[0] == j)
          t_rvalid[j] = ($urandom_range(0, 2) == 0);
        else
          t_rvalid[j] = ($urandom_range(0, 15) == 0);
      end
      t_rdata = {$urandom, $urandom};
      t_ropc  = 2'($urandom);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
